// File: rtl/ng_video_timing_recover_if.sv
`default_nettype none
// ============================================================================
// Module   : ng_video_timing_recover_if
// Purpose  : Video bus between the Neo-Geo core, the timing recovery block and
//            the HDMI encoder. The master side is the video source/sink, the
//            slave side is the timing recovery block.
// Revision : 1.0 - initial release
// ============================================================================
interface ng_video_timing_recover_if #(
    parameter int HCNT_W = 10,
    parameter int VCNT_W = 9
);
    // Raw video from the core
    logic              ce_pix;
    logic              hsync_in;
    logic              vsync_in;
    logic [7:0]        r_in;
    logic [7:0]        g_in;
    logic [7:0]        b_in;

    // Cleaned-up video towards the encoder
    logic [7:0]        r_out;
    logic [7:0]        g_out;
    logic [7:0]        b_out;
    logic              hs_out;
    logic              vs_out;
    logic              hblank;
    logic              vblank;
    logic              de;
    logic [HCNT_W-1:0] line_len;
    logic [VCNT_W-1:0] frame_lines;
    logic              locked;

    modport master (
        output ce_pix, hsync_in, vsync_in, r_in, g_in, b_in,
        input  r_out, g_out, b_out, hs_out, vs_out, hblank, vblank, de,
        input  line_len, frame_lines, locked
    );

    modport slave (
        input  ce_pix, hsync_in, vsync_in, r_in, g_in, b_in,
        output r_out, g_out, b_out, hs_out, vs_out, hblank, vblank, de,
        output line_len, frame_lines, locked
    );
endinterface
`default_nettype wire

// File: rtl/ng_video_timing_recover.sv
`default_nettype none
// ============================================================================
// Module   : ng_video_timing_recover
// Purpose  : Recovers pixel-accurate HBLANK/VBLANK/DE from raw syncs by
//            counting pixel enables from each sync leading edge, measures line
//            and frame length, declares lock once both are stable, and blanks
//            RGB outside the active window.
// Revision : 1.0 - initial release
// ============================================================================
module ng_video_timing_recover #(
    parameter int HCNT_W   = 10,
    parameter int VCNT_W   = 9,
    parameter int H_START  = 28,
    parameter int H_ACTIVE = 320,
    parameter int V_START  = 16,
    parameter int V_ACTIVE = 224,
    parameter bit SYNC_POL = 1'b1
) (
    input  wire logic                  clk_sys,
    input  wire logic                  reset,
    ng_video_timing_recover_if.slave   vid
);

    localparam logic [HCNT_W-1:0] c_hcnt_max  = '1;
    localparam logic [VCNT_W-1:0] c_vcnt_max  = '1;
    // Lengths are held one bit wider so that hcnt+1 and the window end can
    // never wrap.
    localparam logic [HCNT_W:0]   c_hlen_min  = (HCNT_W+1)'(256);
    localparam logic [HCNT_W:0]   c_hlen_lim  = (HCNT_W+1)'((2**HCNT_W) - 1);
    localparam logic [VCNT_W:0]   c_vlen_min  = (VCNT_W+1)'(128);
    localparam logic [VCNT_W:0]   c_vlen_lim  = (VCNT_W+1)'((2**VCNT_W) - 1);
    localparam logic [HCNT_W:0]   c_h_start   = (HCNT_W+1)'(H_START);
    localparam logic [HCNT_W:0]   c_h_end     = (HCNT_W+1)'(H_START + H_ACTIVE);
    localparam logic [VCNT_W:0]   c_v_start   = (VCNT_W+1)'(V_START);
    localparam logic [VCNT_W:0]   c_v_end     = (VCNT_W+1)'(V_START + V_ACTIVE);
    localparam logic [1:0]        c_match_full = 2'd2;

    // State registers and their next-state values
    logic              hs_prev_q, vs_prev_q;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic [HCNT_W-1:0] line_len_q, line_len_d;
    logic [VCNT_W-1:0] frame_lines_q, frame_lines_d;
    logic [1:0]        hmatch_q, hmatch_d;
    logic [1:0]        vmatch_q, vmatch_d;
    logic              locked_q, locked_d;
    logic              hblank_q, hblank_d;
    logic              vblank_q, vblank_d;
    logic              de_q, de_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              hs_out_q, vs_out_q;

    // Combinational helpers
    logic              w_hs_n, w_vs_n;
    logic              w_hs_rise, w_vs_rise;
    logic [HCNT_W:0]   w_h_new_len;
    logic [VCNT_W:0]   w_v_new_len;
    logic              w_h_in, w_v_in;

    assign w_hs_n      = SYNC_POL ? vid.hsync_in : ~vid.hsync_in;
    assign w_vs_n      = SYNC_POL ? vid.vsync_in : ~vid.vsync_in;
    assign w_hs_rise   = w_hs_n & ~hs_prev_q;
    assign w_vs_rise   = w_vs_n & ~vs_prev_q;
    assign w_h_new_len = {1'b0, hcnt_q} + 1'b1;
    assign w_v_new_len = {1'b0, vcnt_q} + 1'b1;

    // Horizontal counter, line length measurement and line-match tracking
    always_comb begin
        hcnt_d     = hcnt_q;
        line_len_d = line_len_q;
        hmatch_d   = hmatch_q;
        if (w_hs_rise) begin
            line_len_d = w_h_new_len[HCNT_W-1:0];
            hcnt_d     = '0;
            if ((w_h_new_len == {1'b0, line_len_q}) &&
                (w_h_new_len >= c_hlen_min) && (w_h_new_len < c_hlen_lim)) begin
                hmatch_d = (hmatch_q == c_match_full) ? c_match_full : hmatch_q + 2'd1;
            end else begin
                hmatch_d = 2'd0;
            end
        end else if (hcnt_q != c_hcnt_max) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        // A runaway line (no hsync) can never be trusted as locked.
        if (hcnt_d == c_hcnt_max) begin
            hmatch_d = 2'd0;
        end
    end

    // Vertical counter, frame height measurement and frame-match tracking;
    // a vsync edge wins over a simultaneous hsync edge.
    always_comb begin
        vcnt_d        = vcnt_q;
        frame_lines_d = frame_lines_q;
        vmatch_d      = vmatch_q;
        if (w_vs_rise) begin
            frame_lines_d = w_v_new_len[VCNT_W-1:0];
            vcnt_d        = '0;
            if ((w_v_new_len == {1'b0, frame_lines_q}) &&
                (w_v_new_len >= c_vlen_min) && (w_v_new_len < c_vlen_lim)) begin
                vmatch_d = (vmatch_q == c_match_full) ? c_match_full : vmatch_q + 2'd1;
            end else begin
                vmatch_d = 2'd0;
            end
        end else if (w_hs_rise && (vcnt_q != c_vcnt_max)) begin
            vcnt_d = vcnt_q + 1'b1;
        end
        if (vcnt_d == c_vcnt_max) begin
            vmatch_d = 2'd0;
        end
    end

    assign w_h_in = ({1'b0, hcnt_d} >= c_h_start) && ({1'b0, hcnt_d} < c_h_end);
    assign w_v_in = ({1'b0, vcnt_d} >= c_v_start) && ({1'b0, vcnt_d} < c_v_end);

    // Lock, window decode and RGB gating, all aligned to the same pixel edge
    always_comb begin
        locked_d = (hmatch_q == c_match_full) && (vmatch_q == c_match_full);
        hblank_d = ~(locked_d & w_h_in);
        vblank_d = ~(locked_d & w_v_in);
        de_d     = ~hblank_d & ~vblank_d;
        r_d      = de_d ? vid.r_in : 8'h00;
        g_d      = de_d ? vid.g_in : 8'h00;
        b_d      = de_d ? vid.b_in : 8'h00;
    end

    // State update on pixel enables; reset takes effect on any clk_sys edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            hmatch_q      <= 2'd0;
            vmatch_q      <= 2'd0;
            locked_q      <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            de_q          <= 1'b0;
            r_q           <= 8'h00;
            g_q           <= 8'h00;
            b_q           <= 8'h00;
            hs_out_q      <= 1'b0;
            vs_out_q      <= 1'b0;
        end else if (vid.ce_pix) begin
            hs_prev_q     <= w_hs_n;
            vs_prev_q     <= w_vs_n;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            hmatch_q      <= hmatch_d;
            vmatch_q      <= vmatch_d;
            locked_q      <= locked_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_out_q      <= w_hs_n;
            vs_out_q      <= w_vs_n;
        end
    end

    assign vid.r_out       = r_q;
    assign vid.g_out       = g_q;
    assign vid.b_out       = b_q;
    assign vid.hs_out      = hs_out_q;
    assign vid.vs_out      = vs_out_q;
    assign vid.hblank      = hblank_q;
    assign vid.vblank      = vblank_q;
    assign vid.de          = de_q;
    assign vid.line_len    = line_len_q;
    assign vid.frame_lines = frame_lines_q;
    assign vid.locked      = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_ng_video_timing_recover.sv
`default_nettype none
// ============================================================================
// Module   : tb_ng_video_timing_recover
// Purpose  : Self-checking bench. DUT A uses active-high syncs, DUT B uses
//            active-low syncs driven with the inverted waveform and gets its
//            own reset. A reference model fills a scoreboard every clk_sys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ng_video_timing_recover;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       de;
        logic [9:0] len;
        logic [8:0] fl;
        logic       lk;
    } exp_t;

    logic clk_sys = 1'b0;
    logic rst_a   = 1'b1;
    logic rst_b   = 1'b1;

    always #5 clk_sys = ~clk_sys;

    ng_video_timing_recover_if vid_a ();
    ng_video_timing_recover_if vid_b ();

    ng_video_timing_recover #(.SYNC_POL(1'b1)) dut_a (
        .clk_sys (clk_sys),
        .reset   (rst_a),
        .vid     (vid_a)
    );

    ng_video_timing_recover #(.SYNC_POL(1'b0)) dut_b (
        .clk_sys (clk_sys),
        .reset   (rst_b),
        .vid     (vid_b)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state, index 0 = DUT A, 1 = DUT B
    int   m_h[2], m_v[2], m_len[2], m_fl[2], m_hm[2], m_vm[2];
    bit   m_hsp[2], m_vsp[2];
    exp_t m_out[2];

    int   de_cnt_a, de_cnt_b, first_de;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset(input int d);
        m_h[d] = 0; m_v[d] = 0; m_len[d] = 0; m_fl[d] = 0;
        m_hm[d] = 0; m_vm[d] = 0; m_hsp[d] = 1'b0; m_vsp[d] = 1'b0;
        m_out[d] = {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0};
    endfunction

    function automatic void m_step(input int d, input bit hs_n, input bit vs_n,
                                   input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit hr, vr, nlk, hwin, vwin, de;
        int nl, nf;
        hr  = hs_n && !m_hsp[d];
        vr  = vs_n && !m_vsp[d];
        nlk = (m_hm[d] == 2) && (m_vm[d] == 2);
        if (hr) begin
            nl = m_h[d] + 1;
            if (nl == m_len[d] && nl >= 256 && nl < 1023) m_hm[d] = (m_hm[d] >= 2) ? 2 : m_hm[d] + 1;
            else m_hm[d] = 0;
            m_len[d] = nl % 1024;
            m_h[d]   = 0;
        end else if (m_h[d] < 1023) begin
            m_h[d] = m_h[d] + 1;
        end
        if (m_h[d] == 1023) m_hm[d] = 0;
        if (vr) begin
            nf = m_v[d] + 1;
            if (nf == m_fl[d] && nf >= 128 && nf < 511) m_vm[d] = (m_vm[d] >= 2) ? 2 : m_vm[d] + 1;
            else m_vm[d] = 0;
            m_fl[d] = nf % 512;
            m_v[d]  = 0;
        end else if (hr && m_v[d] < 511) begin
            m_v[d] = m_v[d] + 1;
        end
        if (m_v[d] == 511) m_vm[d] = 0;
        hwin = nlk && (m_h[d] >= 28) && (m_h[d] < 348);
        vwin = nlk && (m_v[d] >= 16) && (m_v[d] < 240);
        de   = hwin && vwin;
        m_out[d] = {de ? r : 8'h00, de ? g : 8'h00, de ? b : 8'h00, hs_n, vs_n,
                    !hwin, !vwin, de, 10'(m_len[d]), 9'(m_fl[d]), nlk};
        m_hsp[d] = hs_n;
        m_vsp[d] = vs_n;
    endfunction

    // One clk_sys cycle: drive at negedge, predict, compare 1 ns after posedge
    task automatic cyc(input bit ce, input bit hs, input bit vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit ra, input bit rb);
        exp_t ea, eb, ga, gb;
        @(negedge clk_sys);
        vid_a.ce_pix = ce;   vid_b.ce_pix = ce;
        vid_a.hsync_in = hs; vid_b.hsync_in = ~hs;
        vid_a.vsync_in = vs; vid_b.vsync_in = ~vs;
        vid_a.r_in = r; vid_a.g_in = g; vid_a.b_in = b;
        vid_b.r_in = r; vid_b.g_in = g; vid_b.b_in = b;
        rst_a = ra; rst_b = rb;
        if (ra) m_reset(0); else if (ce) m_step(0, hs, vs, r, g, b);
        if (rb) m_reset(1); else if (ce) m_step(1, hs, vs, r, g, b);
        q_a.push_back(m_out[0]);
        q_b.push_back(m_out[1]);
        @(posedge clk_sys);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ga = {vid_a.r_out, vid_a.g_out, vid_a.b_out, vid_a.hs_out, vid_a.vs_out, vid_a.hblank,
              vid_a.vblank, vid_a.de, vid_a.line_len, vid_a.frame_lines, vid_a.locked};
        gb = {vid_b.r_out, vid_b.g_out, vid_b.b_out, vid_b.hs_out, vid_b.vs_out, vid_b.hblank,
              vid_b.vblank, vid_b.de, vid_b.line_len, vid_b.frame_lines, vid_b.locked};
        chk("sb_a", 64'(ga), 64'(ea));
        chk("sb_b", 64'(gb), 64'(eb));
    endtask

    task automatic line(input int len, input int hsw, input bit vs, input int rst_at,
                        input int imin, input int imax);
        int n;
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                cyc(1'b0, 1'($urandom_range(1, 0)), vs, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
                chk("rstb_hblank", 64'(vid_b.hblank), 64'd1);
                chk("rstb_vblank", 64'(vid_b.vblank), 64'd1);
                chk("rstb_de", 64'(vid_b.de), 64'd0);
                chk("rstb_locked", 64'(vid_b.locked), 64'd0);
                chk("rstb_rgb", 64'({vid_b.r_out, vid_b.g_out, vid_b.b_out}), 64'd0);
                chk("rstb_len", 64'({vid_b.line_len, vid_b.frame_lines}), 64'd0);
            end
            n = int'($urandom_range(imax, imin));
            repeat (n) cyc(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                           8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            cyc(1'b1, (i < hsw), vs, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            if (vid_a.de) begin
                de_cnt_a++;
                if (first_de < 0) first_de = i;
            end
            if (vid_b.de) de_cnt_b++;
        end
    endtask

    // 264-line frame: lines lo..hi are 384 px (hsync 32), others 4 px (hsync 1).
    task automatic frame(input int lo, input int hi, input bit special, input bit lockchk,
                         input int imin, input int imax);
        int len, hsw, rst_at;
        for (int l = 0; l < 264; l++) begin
            len    = (l >= lo && l <= hi) ? 384 : 4;
            hsw    = (len == 384) ? 32 : 1;
            rst_at = -1;
            if (special && l == 20) len = 383;
            if (special && l == 25) begin len = 1100; hsw = 0; end
            if (special && l == 16) rst_at = 100;
            de_cnt_a = 0; de_cnt_b = 0; first_de = -1;
            line(len, hsw, (l < 8), rst_at, imin, imax);
            if (special) begin
                if (l == 15) chk("l15_de_count", 64'(de_cnt_a), 64'd0);
                if (l == 16) begin
                    chk("l16_de_count", 64'(de_cnt_a), 64'd320);
                    chk("l16_first_de", 64'(first_de), 64'd28);
                end
                if (l == 21) chk("short_line_unlock", 64'(vid_a.locked), 64'd0);
                if (l == 24) chk("relock", 64'(vid_a.locked), 64'd1);
                if (l == 25) begin
                    chk("sat_locked", 64'(vid_a.locked), 64'd0);
                    chk("sat_de", 64'(vid_a.de), 64'd0);
                    chk("sat_rgb", 64'({vid_a.r_out, vid_a.g_out, vid_a.b_out}), 64'd0);
                end
                if (l == 26) chk("sat_line_len", 64'(vid_a.line_len), 64'd0);
            end
            if (lockchk && l == 16) begin
                chk("a_locked", 64'(vid_a.locked), 64'd1);
                chk("b_relocked", 64'(vid_b.locked), 64'd1);
                chk("b_line_len", 64'(vid_b.line_len), 64'd384);
                chk("b_frame_lines", 64'(vid_b.frame_lines), 64'd264);
                chk("a_de_count", 64'(de_cnt_a), 64'd320);
                chk("b_de_count", 64'(de_cnt_b), 64'd320);
            end
        end
    endtask

    initial begin
        vid_a.ce_pix = 1'b0; vid_b.ce_pix = 1'b0;
        vid_a.hsync_in = 1'b0; vid_b.hsync_in = 1'b1;
        vid_a.vsync_in = 1'b0; vid_b.vsync_in = 1'b1;
        vid_a.r_in = 8'h00; vid_a.g_in = 8'h00; vid_a.b_in = 8'h00;
        vid_b.r_in = 8'h00; vid_b.g_in = 8'h00; vid_b.b_in = 8'h00;
        m_reset(0);
        m_reset(1);

        // Reset with and without pixel enables
        repeat (4) cyc(1'($urandom_range(1, 0)), 1'b1, 1'b1, 8'hAA, 8'h55, 8'hC3, 1'b1, 1'b1);
        chk("rst_hblank", 64'(vid_a.hblank), 64'd1);
        chk("rst_vblank", 64'(vid_a.vblank), 64'd1);
        chk("rst_de", 64'(vid_a.de), 64'd0);
        chk("rst_sync", 64'({vid_a.hs_out, vid_a.vs_out}), 64'd0);
        chk("rst_rgb", 64'({vid_a.r_out, vid_a.g_out, vid_a.b_out}), 64'd0);
        chk("rst_meas", 64'({vid_a.line_len, vid_a.frame_lines, vid_a.locked}), 64'd0);

        // Frame 0 with ce_pix every 8th clk
        frame(-1, -2, 1'b0, 1'b0, 7, 7);
        chk("f0_locked", 64'(vid_a.locked), 64'd0);
        chk("f0_frame_lines", 64'(vid_a.frame_lines), 64'd1);
        frame(-1, -2, 1'b0, 1'b0, 0, 1);
        chk("f1_frame_lines", 64'(vid_a.frame_lines), 64'd264);
        chk("f1_locked", 64'(vid_a.locked), 64'd0);
        frame(261, 263, 1'b0, 1'b0, 0, 1);
        chk("f2_locked", 64'(vid_a.locked), 64'd0);
        chk("f2_line_len", 64'(vid_a.line_len), 64'd384);
        // Locked frame: DE window, short-line unlock, saturation, reset of B
        frame(0, 24, 1'b1, 1'b0, 0, 1);
        chk("f3_frame_lines", 64'(vid_a.frame_lines), 64'd264);
        frame(-1, -2, 1'b0, 1'b0, 0, 1);
        frame(-1, -2, 1'b0, 1'b0, 0, 1);
        frame(261, 263, 1'b0, 1'b0, 0, 1);
        // Both DUTs locked again with identical measurements
        frame(0, 17, 1'b0, 1'b1, 0, 1);
        chk("a_b_same_frame_lines", 64'(vid_a.frame_lines), 64'(vid_b.frame_lines));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
